// File: rtl/twocomp_seq_if.sv
// Valid/ready stream bundle for the word-serial negation sequencer.
// The slave modport is the sequencer side, the master modport is the producer/consumer side.
interface twocomp_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             out_zero;
    logic             out_ovf;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_last,
        output out_zero,
        output out_ovf
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_last,
        input  out_zero,
        input  out_ovf
    );
endinterface

// File: rtl/twocomp_seq.sv
// Word-serial two's-complement negation: streams NWORDS words LSW first through
// a WIDTH-bit invert+increment, chaining the increment carry across words.
module twocomp_seq #(
    parameter int WIDTH  = 8,
    parameter int NWORDS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    twocomp_seq_if.slave  bus
);
    localparam int CW = (NWORDS > 2) ? $clog2(NWORDS) : 1;
    localparam logic [CW-1:0]    LAST_IDX = CW'(NWORDS - 1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] MIN_WORD = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ZERO_WORD = {WIDTH{1'b0}};

    function automatic logic [WIDTH-1:0] neg_word(input logic [WIDTH-1:0] a, input logic c);
        return ~a + {{(WIDTH-1){1'b0}}, c};
    endfunction

    logic [CW-1:0]    cnt_q,       cnt_d;
    logic             carry_q,     carry_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             out_last_q,  out_last_d;
    logic             out_zero_q,  out_zero_d;
    logic             out_ovf_q,   out_ovf_d;

    logic in_ready_s;
    logic accept_s;
    logic is_last_s;
    logic word_zero_s;
    logic word_min_s;

    // The output register can take a new word whenever it is empty or draining this cycle.
    assign in_ready_s  = !out_valid_q || bus.out_ready;
    assign accept_s    = bus.in_valid && in_ready_s;
    assign is_last_s   = (cnt_q == LAST_IDX);
    assign word_zero_s = (bus.in_data == ZERO_WORD);
    assign word_min_s  = (bus.in_data == MIN_WORD);

    // Next-state: counter/carry advance and output capture happen only on accept.
    always_comb begin
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_zero_d  = out_zero_q;
        out_ovf_d   = out_ovf_q;
        if (accept_s) begin
            out_valid_d = 1'b1;
            out_data_d  = neg_word(bus.in_data, carry_q);
            out_last_d  = is_last_s;
            out_zero_d  = is_last_s & carry_q & word_zero_s;
            out_ovf_d   = is_last_s & carry_q & word_min_s;
            if (is_last_s) begin
                // Every operand restarts with the +1 of the negation pending.
                cnt_d   = {CW{1'b0}};
                carry_d = 1'b1;
            end else begin
                cnt_d   = cnt_q + CNT_ONE;
                carry_d = carry_q & word_zero_s;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= {CW{1'b0}};
            carry_q     <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= {WIDTH{1'b0}};
            out_last_q  <= 1'b0;
            out_zero_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_zero_q  <= out_zero_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_zero  = out_zero_q;
    assign bus.out_ovf   = out_ovf_q;
endmodule
